// File: rtl/irq_pending_latch.sv
// ============================================================================
// Module   : irq_pending_latch
// Brief    : Rising-edge interrupt latch with per-line ack, enable mask and
//            sticky overflow flags. Optional macro IRQ_SYNC_EN inserts a
//            two-flop input synchroniser ahead of edge detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_pending_latch #(
    parameter logic [7:0] RESET_MASK = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irq_in,
    input  logic       mask_we,
    input  logic [7:0] mask_wdata,
    input  logic       ack_valid,
    input  logic [2:0] ack_idx,
    input  logic       ov_clr,
    output logic [7:0] pending,
    output logic [7:0] raw_pending,
    output logic [7:0] mask,
    output logic [7:0] overflow,
    output logic       irq_any
);

    logic [7:0] w_s;
    logic [7:0] r_prev;
    logic [7:0] w_event;
    logic [7:0] w_ack_vec;
    logic [7:0] w_ov_set;
    logic [7:0] r_raw;
    logic [7:0] r_ov;
    logic [7:0] r_mask;

`ifdef IRQ_SYNC_EN
    logic [7:0] r_sync1;
    logic [7:0] r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 8'h00;
            r_sync2 <= 8'h00;
        end else begin
            r_sync1 <= irq_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = irq_in;
`endif

    // prev resets low so a line already high at reset release counts as an event
    assign w_event   = w_s & ~r_prev;
    assign w_ack_vec = ack_valid ? (8'h01 << ack_idx) : 8'h00;
    // A new event wins over a same-cycle ack and is not an overflow
    assign w_ov_set  = w_event & r_raw & ~w_ack_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 8'h00;
            r_raw  <= 8'h00;
            r_ov   <= 8'h00;
            r_mask <= RESET_MASK;
        end else begin
            r_prev <= w_s;
            r_raw  <= (r_raw & ~w_ack_vec) | w_event;
            r_ov   <= ov_clr ? w_ov_set : (r_ov | w_ov_set);
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
        end
    end

    assign raw_pending = r_raw;
    assign overflow    = r_ov;
    assign mask        = r_mask;
    assign pending     = r_raw & r_mask;
    assign irq_any     = |pending;

endmodule

`default_nettype wire

// File: tb/tb_irq_pending_latch.sv
// ============================================================================
// Module   : tb_irq_pending_latch
// Brief    : Scoreboard bench for irq_pending_latch (define IRQ_SYNC_EN to
//            exercise the synchronised input path).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_pending_latch;

`ifdef IRQ_SYNC_EN
    localparam int c_LAT = 3;
`else
    localparam int c_LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irq_in = 8'h00;
    logic       mask_we = 1'b0;
    logic [7:0] mask_wdata = 8'h00;
    logic       ack_valid = 1'b0;
    logic [2:0] ack_idx = 3'd0;
    logic       ov_clr = 1'b0;
    logic [7:0] pending;
    logic [7:0] raw_pending;
    logic [7:0] mask;
    logic [7:0] overflow;
    logic       irq_any;

    irq_pending_latch #(.RESET_MASK(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_in      (irq_in),
        .mask_we     (mask_we),
        .mask_wdata  (mask_wdata),
        .ack_valid   (ack_valid),
        .ack_idx     (ack_idx),
        .ov_clr      (ov_clr),
        .pending     (pending),
        .raw_pending (raw_pending),
        .mask        (mask),
        .overflow    (overflow),
        .irq_any     (irq_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] raw;
        logic [7:0] msk;
        logic [7:0] ov;
    } exp_t;

    exp_t q_exp[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Behavioural reference state
    logic [7:0] m_s1, m_s2, m_prev, m_raw, m_ov, m_mask;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 8'h00; m_s2 = 8'h00; m_prev = 8'h00;
        m_raw = 8'h00; m_ov = 8'h00; m_mask = 8'h00;
    endtask

    task automatic compare_outputs(input string tag);
        exp_t e;
        if (q_exp.size() == 0) begin
            check({tag, "_q_empty"}, 8'h01, 8'h00);
            return;
        end
        e = q_exp.pop_front();
        check({tag, "_raw"},  raw_pending, e.raw);
        check({tag, "_mask"}, mask,        e.msk);
        check({tag, "_ov"},   overflow,    e.ov);
        check({tag, "_pend"}, pending,     e.raw & e.msk);
        check({tag, "_any"},  {7'd0, irq_any}, {7'd0, |(e.raw & e.msk)});
    endtask

    // Drive one cycle of stimulus, predict the post-edge state, then compare
    task automatic step(input logic [7:0] irq, input logic we, input logic [7:0] wd,
                        input logic av, input logic [2:0] ai, input logic oc,
                        input string tag);
        logic [7:0] s, ev, ack, ovs;
        exp_t e;
        irq_in = irq; mask_we = we; mask_wdata = wd;
        ack_valid = av; ack_idx = ai; ov_clr = oc;
`ifdef IRQ_SYNC_EN
        s = m_s2;
        m_s2 = m_s1;
        m_s1 = irq;
`else
        s = irq;
`endif
        ev  = s & ~m_prev;
        ack = av ? (8'h01 << ai) : 8'h00;
        ovs = ev & m_raw & ~ack;
        m_raw = (m_raw & ~ack) | ev;
        m_ov  = oc ? ovs : (m_ov | ovs);
        if (we) m_mask = wd;
        m_prev = s;
        e.raw = m_raw; e.msk = m_mask; e.ov = m_ov;
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        compare_outputs(tag);
    endtask

    task automatic idle(input logic [7:0] irq, input int n);
        for (int i = 0; i < n; i++) step(irq, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, "idle");
    endtask

    task automatic do_reset(input logic [7:0] irq);
        irq_in = irq;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_raw",  raw_pending, 8'h00);
        check("rst_ov",   overflow,    8'h00);
        check("rst_mask", mask,        8'h00);
        check("rst_pend", pending,     8'h00);
        check("rst_any",  {7'd0, irq_any}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        do_reset(8'h00);
        @(posedge clk); #1;
        idle(8'h00, 2);

        // Mask all-on, single-cycle pulse on line 5, held after fall, then acked
        step(8'h00, 1'b1, 8'hFF, 1'b0, 3'd0, 1'b0, "mask_ff");
        step(8'h20, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, "pulse5");
        idle(8'h00, c_LAT + 1);
        check("hold5", raw_pending, 8'h20);
        step(8'h00, 1'b0, 8'h00, 1'b1, 3'd5, 1'b0, "ack5");
        check("ack5_clr", raw_pending, 8'h00);

        // Masked line latches but does not raise pending until unmasked
        step(8'h00, 1'b1, 8'h0F, 1'b0, 3'd0, 1'b0, "mask_0f");
        step(8'h40, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, "pulse6");
        idle(8'h00, c_LAT + 1);
        check("m6_raw",  raw_pending, 8'h40);
        check("m6_pend", pending,     8'h00);
        check("m6_any",  {7'd0, irq_any}, 8'h00);
        step(8'h00, 1'b1, 8'hFF, 1'b0, 3'd0, 1'b0, "unmask");
        check("u6_pend", pending, 8'h40);
        check("u6_any",  {7'd0, irq_any}, 8'h01);
        step(8'h00, 1'b0, 8'h00, 1'b1, 3'd6, 1'b0, "ack6");

        // Acking an idle line changes nothing
        step(8'h00, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0, "ack_idle");
        check("ack_idle_ov", overflow, 8'h00);

        // Double edge on line 2 -> overflow; event+ack on line 3 -> no overflow
        step(8'h04, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, "l2_a");
        step(8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, "l2_b");
        step(8'h04, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, "l2_c");
        idle(8'h00, c_LAT + 1);
        check("ov2", overflow, 8'h04);
        step(8'h08, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, "l3_a");
        idle(8'h00, c_LAT + 1);
        for (int i = 0; i < c_LAT; i++)
            step(8'h08, 1'b0, 8'h00, (i == c_LAT - 1), 3'd3, 1'b0, "l3_evack");
        check("evack_raw3", raw_pending & 8'h08, 8'h08);
        check("evack_ov",   overflow, 8'h04);
        step(8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, "ovclr");
        check("ovclr", overflow, 8'h00);

        // Clear and a new overflow in the same edge: set wins
        idle(8'h00, c_LAT);
        for (int i = 0; i < c_LAT; i++)
            step(8'h08, 1'b0, 8'h00, 1'b0, 3'd0, (i == c_LAT - 1), "ovclr_set");
        check("ovclr_setwins", overflow, 8'h08);

        // Randomised traffic against the reference model
        for (int i = 0; i < 60; i++)
            step(8'($urandom), ($urandom_range(0, 7) == 0), 8'($urandom),
                 $urandom_range(0, 1) == 1, 3'($urandom), ($urandom_range(0, 9) == 0), "rand");

        // Mid-operation reset with lines held high through release
        @(posedge clk); #1;
        do_reset(8'h81);
        @(posedge clk); #1;
        idle(8'h81, c_LAT);
        check("rel_raw", raw_pending, 8'h81);

        // Input-to-visibility latency on line 0
        do_reset(8'h00);
        @(posedge clk); #1;
        idle(8'h00, c_LAT + 1);
        step(8'h01, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, "lat_rise");
        for (int i = 1; i < c_LAT; i++) begin
            check("lat_early", raw_pending, 8'h00);
            step(8'h01, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, "lat_wait");
        end
        check("lat_set", raw_pending, 8'h01);

        check("q_drained", 8'(q_exp.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/irq_pending_latch.md
IRQ_PENDING_LATCH -- requirements
Module: irq_pending_latch

Interface
REQ-001 Parameter RESET_MASK, default 8'h00: reset value of the enable mask (bit=1 enables that line).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 irq_in  input  8  raw interrupt request lines, one per source; bit 7 is highest priority downstream.
REQ-005 mask_we  input  1  mask write strobe, sampled on clk.
REQ-006 mask_wdata  input  8  new mask value, loaded when mask_we=1.
REQ-007 ack_valid  input  1  acknowledge strobe from the consumer of the encoded index.
REQ-008 ack_idx  input  3  index of the line being acknowledged (the priority encoder's out code).
REQ-009 ov_clr  input  1  clears all overflow flags.
REQ-010 pending  output  8  raw_pending AND mask; drives the downstream 8-to-3 priority encoder input.
REQ-011 raw_pending  output  8  latched events, independent of mask.
REQ-012 mask  output  8  current enable mask.
REQ-013 overflow  output  8  sticky per-line lost-event flags.
REQ-014 irq_any  output  1  OR-reduction of pending.

Function
REQ-015 Each line SHALL be rising-edge detected against a registered previous sample: event[i] = s[i] & ~prev[i], where s is irq_in (or its synchronised copy, REQ-027).
REQ-016 An event on line i SHALL set raw_pending[i] at the same rising edge at which the event is detected, making it visible the cycle after irq_in rises (no synchroniser).
REQ-017 raw_pending[i] SHALL remain set until acknowledged; input level falling SHALL NOT clear it.
REQ-018 ack_valid=1 SHALL clear raw_pending[ack_idx] at the next rising edge; all other bits are unaffected.
REQ-019 Acknowledging a line whose raw_pending bit is 0 SHALL have no effect and SHALL NOT set overflow.
REQ-020 An event and an ack on the same line in the same cycle: raw_pending stays 1 (new event wins), overflow unchanged.
REQ-021 An event on a line whose raw_pending bit is already 1 and not being acked SHALL set overflow[i]; raw_pending stays 1.
REQ-022 ov_clr=1 SHALL clear all overflow bits at the next edge; if a new overflow condition occurs in the same cycle, that bit SHALL be set (set wins).
REQ-023 mask_we=1 SHALL load mask_wdata at the next edge; the mask gates only pending/irq_any, never latching or overflow detection.
REQ-024 pending and irq_any SHALL be combinational from registered raw_pending and mask (no extra latency).

Reset
REQ-025 While rst_n=0: raw_pending=8'h00, overflow=8'h00, mask=RESET_MASK, prev samples and synchroniser flops=0, hence pending=0, irq_any=0.
REQ-026 Because prev resets to 0, a line already high when rst_n deasserts SHALL be captured as an event on the first edge after reset; assertion of rst_n mid-operation discards all pending events immediately.

Configuration
REQ-027 Macro IRQ_SYNC_EN: when defined, each irq_in bit SHALL pass through a two-flop synchroniser before edge detection, adding exactly 2 cycles (raw_pending visible 3 cycles after irq_in rises); when undefined, irq_in feeds edge detection directly (1 cycle). All other behaviour is identical.

Verification (IRQ_SYNC_EN undefined unless stated)
REQ-028 Reset, RESET_MASK=8'h00, irq_in=8'h00 -> pending=0, raw_pending=0, overflow=0, irq_any=0.
REQ-029 mask=8'hFF, pulse irq_in[5] one cycle -> raw_pending=8'h20 one cycle later and held after irq_in falls; ack_idx=5, ack_valid=1 -> raw_pending=8'h00 next cycle.
REQ-030 mask=8'h0F, pulse irq_in[6] -> raw_pending=8'h40, pending=8'h00, irq_any=0; then write mask=8'hFF -> pending=8'h40, irq_any=1.
REQ-031 raw_pending[2]=1, second rising edge on irq_in[2] without ack -> overflow=8'h04; same cycle event+ack on line 3 -> raw_pending[3]=1, overflow[3]=0; ov_clr -> overflow=8'h00.
REQ-032 irq_in=8'h81 held through rst_n release -> raw_pending=8'h81 after first edge; with IRQ_SYNC_EN defined, irq_in[0] rises -> raw_pending[0] set exactly 3 cycles later.
